key_event_ctrl: RTL and testbench

- Front-panel event scheduler downstream of the per-key debouncers in the SD/WM8731/FFT/WS2812 design.
- Takes each debounced key's one-cycle press/release pulses and classifies them with a per-key state machine into SHORT, DOUBLE or LONG events.
- Arbitrates round-robin among keys with pending events and queues {key, code} into a small show-ahead FIFO with a valid/ready consumer interface (mode/volume/display control logic).

---
 rtl/key_event_ctrl.sv | 132 +++++++++++++
 tb/tb_key_event_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// key_event_ctrl: classifies debounced key pulses into SHORT/DOUBLE/LONG events and queues them round-robin into a show-ahead FIFO.
module key_event_ctrl #(
  parameter int NUM_KEYS   = 4,
  parameter int KEY_W      = 2,
  parameter int FREQ       = 50,
  parameter int LONG_MS    = 1000,
  parameter int DCLICK_MS  = 300,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_KEYS-1:0]         key_press_i,
  input  logic [NUM_KEYS-1:0]         key_release_i,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [KEY_W-1:0]            evt_key_o,
  output logic [1:0]                  evt_code_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        overflow_o,
  input  logic                        overflow_clr_i
);
  localparam int TC = FREQ * 1000;
  localparam int TW = $clog2(TC);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] SHORT = 2'd0, DOUBLE = 2'd1, LONG = 2'd2;
  typedef enum logic [2:0] {IDLE, PRESS1, HOLD, GAP, PRESS2} state_t;
  logic [TW-1:0] pre_q, pre_d;
  logic tick;
  state_t st_q [NUM_KEYS];
  state_t st_d [NUM_KEYS];
  logic [15:0] ms_q [NUM_KEYS];
  logic [15:0] ms_d [NUM_KEYS];
  logic [1:0] ecode [NUM_KEYS];
  logic [1:0] pcode_q [NUM_KEYS];
  logic [1:0] pcode_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] pr, rl, emit, pend_q, pend_d, gnt;
  logic [KEY_W-1:0] rr_q, rr_d, gidx;
  logic found, push, pop, full, ovf_q, ovf_d;
  logic [KEY_W+1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] lvl_q;
  assign tick = pre_q == TW'(TC - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  // simultaneous press and release on one key cancel each other
  assign pr = key_press_i & ~key_release_i;
  assign rl = key_release_i & ~key_press_i;
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      st_d[i] = st_q[i];
      emit[i] = 1'b0;
      ecode[i] = SHORT;
      case (st_q[i])
        IDLE:   if (pr[i]) st_d[i] = PRESS1;
        PRESS1: if (rl[i]) st_d[i] = GAP;
                else if (tick && ms_q[i] == 16'(LONG_MS - 1)) begin
                  st_d[i] = HOLD;
                  emit[i] = 1'b1;
                  ecode[i] = LONG;
                end
        HOLD:   if (rl[i]) st_d[i] = IDLE;
        GAP:    if (pr[i]) st_d[i] = PRESS2;
                else if (tick && ms_q[i] == 16'(DCLICK_MS - 1)) begin
                  st_d[i] = IDLE;
                  emit[i] = 1'b1;
                end
        PRESS2: if (rl[i]) begin
                  st_d[i] = IDLE;
                  emit[i] = 1'b1;
                  ecode[i] = DOUBLE;
                end
        default: st_d[i] = IDLE;
      endcase
      ms_d[i] = st_d[i] != st_q[i] ? '0 : ms_q[i] + 16'(tick);
      pcode_d[i] = emit[i] ? ecode[i] : pcode_q[i];
    end
  end
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!found && pend_q[(int'(rr_q) + k) % NUM_KEYS]) begin
        found = 1'b1;
        gidx = KEY_W'((int'(rr_q) + k) % NUM_KEYS);
      end
    end
  end
  assign pop = evt_valid_o & evt_ready_i;
  assign full = lvl_q == (AW+1)'(FIFO_DEPTH);
  assign push = found & (~full | pop);
  assign gnt = push ? NUM_KEYS'(1) << gidx : '0;
  assign rr_d = gidx == KEY_W'(NUM_KEYS - 1) ? '0 : gidx + 1'b1;
  // a fresh emission replaces a pending one unless that one is granted now
  assign pend_d = emit | (pend_q & ~gnt);
  assign ovf_d = |(emit & pend_q & ~gnt) | (ovf_q & ~overflow_clr_i);
  assign evt_valid_o = lvl_q != '0;
  assign {evt_key_o, evt_code_o} = mem_q[rd_q];
  assign fifo_level_o = lvl_q;
  assign overflow_o = ovf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
      pend_q <= '0;
      rr_q <= '0;
      ovf_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      lvl_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i] <= IDLE;
        ms_q[i] <= '0;
        pcode_q[i] <= SHORT;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      pre_q <= pre_d;
      pend_q <= pend_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        st_q[i] <= st_d[i];
        ms_q[i] <= ms_d[i];
        pcode_q[i] <= pcode_d[i];
      end
      if (push) begin
        mem_q[wr_q] <= {gidx, pcode_q[gidx]};
        wr_q <= wr_q + 1'b1;
        rr_q <= rr_d;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_key_event_ctrl.sv
// tb_key_event_ctrl: directed checks of key classification, arbitration order, FIFO full/overflow and reset.
module tb_key_event_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] kp = '0, kr = '0;
  logic ready = 1'b0, clr = 1'b0;
  logic valid, ovf;
  logic [1:0] key, code;
  logic [2:0] level;
  int checks = 0, errors = 0;
  key_event_ctrl #(
    .NUM_KEYS(4), .KEY_W(2), .FREQ(1), .LONG_MS(10), .DCLICK_MS(3), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .key_press_i(kp), .key_release_i(kr),
    .evt_valid_o(valid), .evt_ready_i(ready), .evt_key_o(key), .evt_code_o(code),
    .fifo_level_o(level), .overflow_o(ovf), .overflow_clr_i(clr)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic press(input logic [3:0] m);
    kp = m;
    step(1);
    kp = '0;
  endtask
  task automatic rel(input logic [3:0] m);
    kr = m;
    step(1);
    kr = '0;
  endtask
  task automatic pop1();
    ready = 1'b1;
    step(1);
    ready = 1'b0;
  endtask
  task automatic tap(input logic [3:0] m, input int hold);
    press(m);
    step(hold);
    rel(m);
  endtask
  task automatic dbl(input logic [3:0] m);
    tap(m, 200);
    step(200);
    tap(m, 200);
  endtask
  task automatic wait_valid(input int maxc, input string tag);
    int n = 0;
    while (!valid && n < maxc) begin
      step(1);
      n++;
    end
    chk(tag, 32'(valid), 1);
  endtask
  initial begin
    step(3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_key", 32'(key), 0);
    chk("rst_code", 32'(code), 0);
    rst = 1'b0;
    step(2);
    dbl(4'b1001);
    chk("pair_a_lat", 32'(valid), 0);
    step(1);
    chk("pair_a_lvl1", 32'(level), 1);
    chk("pair_a_key0", 32'(key), 0);
    chk("pair_a_code0", 32'(code), 1);
    step(1);
    chk("pair_a_lvl2", 32'(level), 2);
    pop1();
    chk("pair_a_key1", 32'(key), 3);
    chk("pair_a_code1", 32'(code), 1);
    pop1();
    chk("pair_a_empty", 32'(level), 0);
    tap(4'b0010, 2000);
    step(2000);
    chk("short_early", 32'(valid), 0);
    wait_valid(1100, "short_valid");
    chk("short_key", 32'(key), 1);
    chk("short_code", 32'(code), 0);
    chk("short_lvl", 32'(level), 1);
    pop1();
    chk("short_pop_lvl", 32'(level), 0);
    chk("short_pop_valid", 32'(valid), 0);
    dbl(4'b0100);
    chk("dbl_lat", 32'(valid), 0);
    step(1);
    chk("dbl_valid", 32'(valid), 1);
    chk("dbl_key", 32'(key), 2);
    chk("dbl_code", 32'(code), 1);
    pop1();
    step(4000);
    chk("dbl_no_short", 32'(level), 0);
    press(4'b0001);
    step(9000);
    chk("long_early", 32'(valid), 0);
    wait_valid(1100, "long_valid");
    chk("long_key", 32'(key), 0);
    chk("long_code", 32'(code), 2);
    pop1();
    step(6000);
    rel(4'b0001);
    step(4000);
    chk("long_rel_none", 32'(level), 0);
    dbl(4'b1001);
    step(2);
    chk("pair_b_lvl", 32'(level), 2);
    chk("pair_b_key0", 32'(key), 3);
    pop1();
    chk("pair_b_key1", 32'(key), 0);
    pop1();
    chk("pair_b_empty", 32'(level), 0);
    tap(4'b1111, 200);
    step(3100);
    chk("fill_lvl", 32'(level), 4);
    chk("fill_head", 32'(key), 1);
    chk("fill_ovf", 32'(ovf), 0);
    tap(4'b0010, 200);
    step(3100);
    chk("full_lvl", 32'(level), 4);
    chk("full_ovf0", 32'(ovf), 0);
    tap(4'b0010, 200);
    step(3100);
    chk("full_ovf1", 32'(ovf), 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    pop1();
    chk("refill_lvl", 32'(level), 4);
    chk("refill_head", 32'(key), 2);
    ready = 1'b1;
    step(3);
    ready = 1'b0;
    chk("tail_key", 32'(key), 1);
    chk("tail_code", 32'(code), 0);
    chk("tail_lvl", 32'(level), 1);
    pop1();
    chk("drain_lvl", 32'(level), 0);
    dbl(4'b1001);
    step(2);
    chk("pre_rst_lvl", 32'(level), 2);
    tap(4'b0010, 200);
    step(500);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(valid), 0);
    chk("mid_rst_lvl", 32'(level), 0);
    step(2);
    rst = 1'b0;
    step(4000);
    chk("post_rst_none", 32'(level), 0);
    tap(4'b0010, 200);
    step(3100);
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_key", 32'(key), 1);
    chk("post_rst_code", 32'(code), 0);
    chk("post_rst_lvl", 32'(level), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
